// File: rtl/mux_rr_arbiter_4_if.sv
// Bundle between two requesters and the shared 2:1 mux arbiter.
// Optional macro: ARB_LOCK_EN adds lock_a / lock_b.
// Signals:
//   req_a, req_b      requests (driven by the requesters)
//   a, b              requester data words (W bits)
//   lock_a, lock_b    tenure lock requests (only with ARB_LOCK_EN)
//   gnt_a, gnt_b      registered grants (driven by the arbiter)
//   sel               mux select, 0 = a, 1 = b
//   o, o_valid        registered mux output and its valid flag
//   busy              arbiter is not idle
interface mux_rr_arbiter_4_if #(
  parameter int unsigned W = 4
);
  logic         req_a;
  logic         req_b;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         gnt_a;
  logic         gnt_b;
  logic         sel;
  logic [W-1:0] o;
  logic         o_valid;
  logic         busy;

`ifdef ARB_LOCK_EN
  logic lock_a;
  logic lock_b;

  modport master (
    output req_a, req_b, a, b, lock_a, lock_b,
    input  gnt_a, gnt_b, sel, o, o_valid, busy
  );

  modport slave (
    input  req_a, req_b, a, b, lock_a, lock_b,
    output gnt_a, gnt_b, sel, o, o_valid, busy
  );
`else
  modport master (
    output req_a, req_b, a, b,
    input  gnt_a, gnt_b, sel, o, o_valid, busy
  );

  modport slave (
    input  req_a, req_b, a, b,
    output gnt_a, gnt_b, sel, o, o_valid, busy
  );
`endif
endinterface

// File: rtl/mux_rr_arbiter_4.sv
// Round-robin arbiter/sequencer sharing one 2:1 W-bit mux between requester A
// (sel=0) and requester B (sel=1). Grants one requester per tenure of up to HOLD
// cycles and registers the selected word with a valid flag.
// Optional macro: ARB_LOCK_EN adds lock_a/lock_b; a locked, still-requesting owner
// keeps its tenure past the HOLD limit.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   mux_rr_arbiter_4_if.slave (requests, data, grants, sel, o, o_valid, busy)
module mux_rr_arbiter_4 #(
  parameter int unsigned W    = 4,
  parameter int unsigned HOLD = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  mux_rr_arbiter_4_if.slave      bus
);

  localparam int unsigned CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic           last;      // 1 = B held the most recent tenure
  logic           gnt_a_q;
  logic           gnt_b_q;
  logic           sel_q;
  logic [W-1:0]   o_q;
  logic           o_valid_q;
  logic           busy_q;

  logic           req_cur;
  logic           lock_cur;
  logic           at_limit;
  logic           tenure_end;
  logic           rearb;
  logic           last_eff;
  logic           any_req;
  logic           pick_b;

  // Tenure-end and arbitration decision for the current cycle.
  always_comb begin
    req_cur    = 1'b0;
    lock_cur   = 1'b0;
    at_limit   = (cnt == CW'(HOLD - 1));
    tenure_end = 1'b0;
    rearb      = 1'b0;
    last_eff   = last;
    any_req    = bus.req_a | bus.req_b;
    pick_b     = 1'b0;

    if (state == GNT_A) begin
      req_cur = bus.req_a;
`ifdef ARB_LOCK_EN
      lock_cur = bus.lock_a;
`endif
    end else if (state == GNT_B) begin
      req_cur = bus.req_b;
`ifdef ARB_LOCK_EN
      lock_cur = bus.lock_b;
`endif
    end

    tenure_end = (state != IDLE) && (!req_cur || (at_limit && !lock_cur));
    rearb      = (state == IDLE) || tenure_end;

    // At tenure end the owner becomes 'last' this edge, so arbitrate against it now;
    // this gives a direct switch when the other side is waiting.
    if (state != IDLE) last_eff = (state == GNT_B);
    pick_b = bus.req_b && (!bus.req_a || !last_eff);
  end

  // State, tenure counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      last      <= 1'b1;
      gnt_a_q   <= 1'b0;
      gnt_b_q   <= 1'b0;
      sel_q     <= 1'b0;
      o_q       <= '0;
      o_valid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      if (state == IDLE) begin
        o_valid_q <= 1'b0;
      end else begin
        o_q       <= sel_q ? bus.b : bus.a;
        o_valid_q <= 1'b1;
      end

      if (tenure_end) last <= (state == GNT_B);

      if (rearb) begin
        cnt <= '0;
        if (any_req) begin
          state   <= pick_b ? GNT_B : GNT_A;
          gnt_a_q <= !pick_b;
          gnt_b_q <= pick_b;
          sel_q   <= pick_b;
          busy_q  <= 1'b1;
        end else begin
          state   <= IDLE;
          gnt_a_q <= 1'b0;
          gnt_b_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      end else if (!at_limit) begin
        // Reaching the limit without ending means locked: saturate.
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign bus.gnt_a   = gnt_a_q;
  assign bus.gnt_b   = gnt_b_q;
  assign bus.sel     = sel_q;
  assign bus.o       = o_q;
  assign bus.o_valid = o_valid_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_mux_rr_arbiter_4.sv
// Scoreboard bench for mux_rr_arbiter_4: two instances (HOLD=2 and HOLD=1) share
// the same stimulus; a tenure-level reference model predicts each output set.
module tb_mux_rr_arbiter_4;

  typedef struct packed {
    logic       gnt_a;
    logic       gnt_b;
    logic       sel;
    logic [3:0] o;
    logic       o_valid;
    logic       busy;
  } out_t;

  localparam int HOLD0 = 2;
  localparam int HOLD1 = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a = 1'b0;
  logic       req_b = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
`ifdef ARB_LOCK_EN
  logic       lock_a = 1'b0;
  logic       lock_b = 1'b0;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  mux_rr_arbiter_4_if #(.W(4)) if0 ();
  mux_rr_arbiter_4_if #(.W(4)) if1 ();

  assign if0.req_a = req_a;
  assign if0.req_b = req_b;
  assign if0.a     = a;
  assign if0.b     = b;
  assign if1.req_a = req_a;
  assign if1.req_b = req_b;
  assign if1.a     = a;
  assign if1.b     = b;
`ifdef ARB_LOCK_EN
  assign if0.lock_a = lock_a;
  assign if0.lock_b = lock_b;
  assign if1.lock_a = lock_a;
  assign if1.lock_b = lock_b;
`endif

  mux_rr_arbiter_4 #(.W(4), .HOLD(HOLD0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  mux_rr_arbiter_4 #(.W(4), .HOLD(HOLD1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  always #5 clk = ~clk;

  out_t act0, act1;
  assign act0 = {if0.gnt_a, if0.gnt_b, if0.sel, if0.o, if0.o_valid, if0.busy};
  assign act1 = {if1.gnt_a, if1.gnt_b, if1.sel, if1.o, if1.o_valid, if1.busy};

  out_t q0[$];
  out_t q1[$];

  // Reference model: owner 0 = none, 1 = A, 2 = B; used = granted cycles completed.
  int         owner[2];
  int         used[2];
  int         last[2];
  logic [3:0] mo[2];
  bit         mov[2];
  bit         msel[2];

  task automatic check(input string name, input out_t act, input out_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got gnt_a=%b gnt_b=%b sel=%b o=%b o_valid=%b busy=%b, expected gnt_a=%b gnt_b=%b sel=%b o=%b o_valid=%b busy=%b",
               name, $time, act.gnt_a, act.gnt_b, act.sel, act.o, act.o_valid, act.busy,
               exp.gnt_a, exp.gnt_b, exp.sel, exp.o, exp.o_valid, exp.busy);
    end
  endtask

  function automatic out_t model_out(input int i);
    out_t r;
    r.gnt_a   = (owner[i] == 1);
    r.gnt_b   = (owner[i] == 2);
    r.sel     = msel[i];
    r.o       = mo[i];
    r.o_valid = mov[i];
    r.busy    = (owner[i] != 0);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      owner[i] = 0; used[i] = 0; last[i] = 2;
      mo[i] = '0; mov[i] = 0; msel[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input int hold, input bit ra, input bit rb,
                            input bit la, input bit lb, input logic [3:0] da,
                            input logic [3:0] db);
    bit own_req;
    bit own_lock;
    bit ending;
    own_req  = (owner[i] == 1) ? ra : (owner[i] == 2) ? rb : 1'b0;
    own_lock = (owner[i] == 1) ? la : (owner[i] == 2) ? lb : 1'b0;
    if (owner[i] == 1)      begin mo[i] = da; mov[i] = 1; end
    else if (owner[i] == 2) begin mo[i] = db; mov[i] = 1; end
    else                    mov[i] = 0;
    ending = (owner[i] == 0) || !own_req || ((used[i] + 1 >= hold) && !own_lock);
    if (ending) begin
      if (owner[i] != 0) last[i] = owner[i];
      if (ra && rb)  owner[i] = (last[i] == 1) ? 2 : 1;
      else if (ra)   owner[i] = 1;
      else if (rb)   owner[i] = 2;
      else           owner[i] = 0;
      used[i] = 0;
    end else begin
      used[i] = used[i] + 1;
    end
    if (owner[i] != 0) msel[i] = (owner[i] == 2);
  endtask

  // One clocked cycle of stimulus; expectation for the next edge is queued.
  task automatic cycle(input bit ra, input bit rb, input logic [3:0] da,
                       input logic [3:0] db, input bit la, input bit lb);
    @(negedge clk);
    #1;
    rst = 1'b0;
    req_a = ra; req_b = rb; a = da; b = db;
`ifdef ARB_LOCK_EN
    lock_a = la; lock_b = lb;
`else
    la = 1'b0; lb = 1'b0;
`endif
    model_step(0, HOLD0, ra, rb, la, lb, da, db);
    model_step(1, HOLD1, ra, rb, la, lb, da, db);
    q0.push_back(model_out(0));
    q1.push_back(model_out(1));
  endtask

  // Asynchronous reset between edges, checked immediately without a clock.
  task automatic do_reset();
    out_t zero;
    zero = '0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("async_reset_hold2", act0, zero);
    check("async_reset_hold1", act1, zero);
    model_reset();
    q0.push_back(model_out(0));
    q1.push_back(model_out(1));
  endtask

  // Monitor: compare whatever the DUTs present after each active edge.
  always @(negedge clk) begin
    if (q0.size() > 0) check("hold2", act0, q0.pop_front());
    if (q1.size() > 0) check("hold1", act1, q1.pop_front());
  end

  initial begin
    model_reset();
    do_reset();

    // GNT_B tenure interrupted by an asynchronous reset.
    cycle(0, 1, 4'h0, 4'b0001, 0, 0);
    cycle(0, 1, 4'h0, 4'b0001, 0, 0);
    do_reset();

    // Sole requester A: back-to-back regrants.
    for (int k = 0; k < 6; k++) cycle(1, 0, 4'b1010, 4'b0001, 0, 0);
    for (int k = 0; k < 2; k++) cycle(0, 0, 4'b1010, 4'b0001, 0, 0);

    // Both requesting: alternating tenures.
    for (int k = 0; k < 8; k++) cycle(1, 1, 4'b1010, 4'b0001, 0, 0);
    for (int k = 0; k < 2; k++) cycle(0, 0, 4'b1010, 4'b0001, 0, 0);

    // B drops its request early with A idle.
    cycle(0, 1, 4'b1010, 4'b0001, 0, 0);
    cycle(0, 1, 4'b1010, 4'b0001, 0, 0);
    for (int k = 0; k < 3; k++) cycle(0, 0, 4'b0110, 4'b1111, 0, 0);

`ifdef ARB_LOCK_EN
    // Lock holds A's tenure past the limit; release lets B in.
    for (int k = 0; k < 6; k++) cycle(1, 1, 4'b1010, 4'b0001, 1, 0);
    for (int k = 0; k < 3; k++) cycle(1, 1, 4'b1010, 4'b0001, 0, 0);
    for (int k = 0; k < 2; k++) cycle(0, 0, 4'b1010, 4'b0001, 0, 0);
`endif

    // Randomized traffic with occasional asynchronous resets.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 49) == 0) begin
        do_reset();
      end else begin
        cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
              4'($urandom), 4'($urandom),
              1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0));
      end
    end

    for (int k = 0; k < 3; k++) cycle(0, 0, 4'h0, 4'h0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    #2;
    n_chk++;
    if (q0.size() + q1.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q0.size() + q1.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
